// File: rtl/bf_pair_sequencer_pkg.sv
// Shared FFT definitions: default float width, unity twiddle constant and
// the pair-sequencer state encoding.
package bf_pair_sequencer_pkg;

    localparam int FFT_FLOAT_LEN = 32;

    localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
    localparam logic [63:0] TF_UNITY_FP32 = {FP32_ONE, 32'h0000_0000};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // 1.0+0j for the supported IEEE formats, right-justified so callers can truncate.
    function automatic logic [127:0] unity_twiddle(input int unsigned float_len);
        logic [127:0] w;
        case (float_len)
            16:      w = {96'd0, 16'h3C00, 16'h0000};
            64:      w = {64'h3FF0_0000_0000_0000, 64'h0};
            default: w = {64'd0, TF_UNITY_FP32};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth valid/data delay line; data stages only load behind a valid,
// so the output data holds its last valid value during gaps.
module fft_delay_line #(
    parameter int DATA_W = 8,
    parameter int STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic [STAGES-1:0] vld_q;
    logic [DATA_W-1:0] data_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign vld_o  = vld_q[STAGES-1];
    assign data_o = data_q[STAGES-1];

endmodule

// File: rtl/bf_pair_sequencer.sv
// Butterfly pair sequencer: counts pairs per frame, addresses the twiddle ROM
// and aligns x1/x2 with the returned twiddle. Optional macro: BF_TF_UNITY_EN.
module bf_pair_sequencer
    import bf_pair_sequencer_pkg::*;
#(
    parameter int FLOAT_LEN   = FFT_FLOAT_LEN,
    parameter int TF_ADDR_LEN = 12,
    parameter int SPAN_LOG2   = 12,
    parameter int TF_LATENCY  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*FLOAT_LEN-1:0]   data_in1,
    input  logic [2*FLOAT_LEN-1:0]   data_in2,
    input  logic                     data_in_valid,
    output logic [TF_ADDR_LEN-1:0]   tf_addr,
    output logic                     tf_rd_en,
    input  logic [2*FLOAT_LEN-1:0]   tf_data,
    output logic [2*FLOAT_LEN-1:0]   x1_out,
    output logic [2*FLOAT_LEN-1:0]   x2_out,
    output logic [2*FLOAT_LEN-1:0]   tf_out,
    output logic                     data_out_valid,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int CW     = 2 * FLOAT_LEN;
    localparam int SHIFT  = TF_ADDR_LEN - SPAN_LOG2;
    localparam int OPEN_W = $clog2(TF_LATENCY + 2) + 1;
`ifdef BF_TF_UNITY_EN
    localparam int FLAG_W = 2;
    localparam logic [CW-1:0] TF_UNITY = CW'(unity_twiddle(unsigned'(FLOAT_LEN)));
`else
    localparam int FLAG_W = 1;
`endif
    localparam int DW = 2 * CW + FLAG_W;

    seq_state_e              state_q, state_d;
    logic [TF_ADDR_LEN-1:0]  pc_q, pc_d;
    logic [OPEN_W-1:0]       open_q, open_d;
    logic [CW-1:0]           tf_hold_q;
    logic [SPAN_LOG2-1:0]    k;
    logic                    last_pair;
    logic                    start;
    logic [FLAG_W-1:0]       flags_in, flags_out;
    logic [DW-1:0]           dly_data;
    logic                    dly_vld;
    logic [CW-1:0]           tf_sel;
`ifdef BF_TF_UNITY_EN
    logic                    k_zero;
`endif

    assign k         = pc_q[SPAN_LOG2-1:0];
    assign last_pair = &pc_q;
    assign start     = (state_q == ST_IDLE) && data_in_valid;
    assign tf_addr   = TF_ADDR_LEN'(k) << SHIFT;

`ifdef BF_TF_UNITY_EN
    // k==0 twiddle is 1.0+0j, so the ROM is not read for those pairs.
    assign k_zero   = (k == '0);
    assign tf_rd_en = data_in_valid && !k_zero;
    assign flags_in = {last_pair, k_zero};
`else
    assign tf_rd_en = data_in_valid;
    assign flags_in = last_pair;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (data_in_valid) begin
                    pc_d    = TF_ADDR_LEN'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (data_in_valid) begin
                    if (last_pair) begin
                        pc_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        pc_d = pc_q + TF_ADDR_LEN'(1);
                    end
                end
            end
            default: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frames still owed a frame_done; covers a new frame starting while the
    // previous frame's tail is still in the delay line.
    always_comb begin
        open_d = open_q;
        case ({start, frame_done})
            2'b10:   open_d = open_q + OPEN_W'(1);
            2'b01:   open_d = open_q - OPEN_W'(1);
            default: open_d = open_q;
        endcase
    end

    assign busy = (open_q != '0) || start;

    fft_delay_line #(
        .DATA_W (DW),
        .STAGES (TF_LATENCY)
    ) u_align (
        .clk_i  (clk),
        .rst_ni (rst),
        .vld_i  (data_in_valid),
        .data_i ({data_in1, data_in2, flags_in}),
        .vld_o  (dly_vld),
        .data_o (dly_data)
    );

    assign flags_out      = dly_data[FLAG_W-1:0];
    assign x1_out         = dly_data[DW-1 -: CW];
    assign x2_out         = dly_data[DW-CW-1 -: CW];
    assign data_out_valid = dly_vld;
    assign frame_done     = dly_vld && flags_out[FLAG_W-1];

`ifdef BF_TF_UNITY_EN
    assign tf_sel = flags_out[0] ? TF_UNITY : tf_data;
`else
    assign tf_sel = tf_data;
`endif

    // tf_data is free-running from the ROM, so the last valid twiddle is latched.
    assign tf_out = dly_vld ? tf_sel : tf_hold_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            open_q    <= '0;
            tf_hold_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            open_q  <= open_d;
            if (dly_vld) begin
                tf_hold_q <= tf_sel;
            end
        end
    end

endmodule

// File: tb/tb_bf_pair_sequencer.sv
// Self-checking bench for bf_pair_sequencer with a queue-based frame model;
// honours BF_TF_UNITY_EN when defined.
module tb_bf_pair_sequencer;

    localparam int FL  = 32;
    localparam int AL  = 3;
    localparam int SL  = 2;
    localparam int LAT = 2;
    localparam int NP  = 1 << AL;
    localparam logic [63:0] UNITY = 64'h3F800000_00000000;
    localparam logic [63:0] NOREAD = 64'hBAD0_BAD0_BAD0_BAD0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [63:0]   data_in1 = '0;
    logic [63:0]   data_in2 = '0;
    logic          data_in_valid = 1'b0;
    logic [AL-1:0] tf_addr;
    logic          tf_rd_en;
    logic [63:0]   tf_data;
    logic [63:0]   x1_out, x2_out, tf_out;
    logic          data_out_valid, frame_done, busy;
    logic [63:0]   rom_p1 = '0, rom_p2 = '0;

    always #5 clk = ~clk;

    // ROM: word {addr, addr} appears LAT cycles after the read strobe.
    always @(posedge clk) begin
        rom_p1 <= tf_rd_en ? {32'(tf_addr), 32'(tf_addr)} : NOREAD;
        rom_p2 <= rom_p1;
    end
    assign tf_data = rom_p2;

    bf_pair_sequencer #(
        .FLOAT_LEN   (FL),
        .TF_ADDR_LEN (AL),
        .SPAN_LOG2   (SL),
        .TF_LATENCY  (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in1       (data_in1),
        .data_in2       (data_in2),
        .data_in_valid  (data_in_valid),
        .tf_addr        (tf_addr),
        .tf_rd_en       (tf_rd_en),
        .tf_data        (tf_data),
        .x1_out         (x1_out),
        .x2_out         (x2_out),
        .tf_out         (tf_out),
        .data_out_valid (data_out_valid),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    wire [198:0] obs = {data_out_valid, frame_done, busy, tf_rd_en, tf_addr,
                        x1_out, x2_out, tf_out};

    typedef struct {
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] tf;
        bit          done;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          m_pc;
    int          cyc;
    logic [63:0] h_x1, h_x2, h_tf;
    int          checks = 0;
    int          errors = 0;

    function automatic bit unity_on();
`ifdef BF_TF_UNITY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        q.delete();
        m_pc = 0;
        h_x1 = '0;
        h_x2 = '0;
        h_tf = '0;
    endfunction

    // Expected observation for the current cycle given this cycle's valid.
    function automatic void model_expect(input bit v, output logic [198:0] e);
        int  k    = m_pc % (1 << SL);
        int  addr = k << (AL - SL);
        bit  rd   = v && !(unity_on() && k == 0);
        bit  owed = 1'b0;
        bit  ov   = 1'b0;
        bit  od   = 1'b0;
        bit  bz;
        foreach (q[i]) if (q[i].done) owed = 1'b1;
        bz = (m_pc != 0) || v || owed;
        if (q.size() > 0 && q[0].due == cyc) begin
            ov   = 1'b1;
            od   = q[0].done;
            h_x1 = q[0].x1;
            h_x2 = q[0].x2;
            h_tf = q[0].tf;
            void'(q.pop_front());
        end
        e = {ov, od, bz, rd, 3'(addr), h_x1, h_x2, h_tf};
    endfunction

    function automatic void model_accept(input bit v, input logic [63:0] d1, input logic [63:0] d2);
        exp_t t;
        int   k;
        if (!v) return;
        k      = m_pc % (1 << SL);
        t.x1   = d1;
        t.x2   = d2;
        t.tf   = (unity_on() && k == 0) ? UNITY : {32'(k << (AL - SL)), 32'(k << (AL - SL))};
        t.done = (m_pc == NP - 1);
        t.due  = cyc + LAT;
        q.push_back(t);
        m_pc   = (m_pc + 1) % NP;
    endfunction

    task automatic drive(input bit v);
        data_in_valid = v;
        data_in1 = {$urandom, $urandom};
        data_in2 = {$urandom, $urandom};
        #1;
    endtask

    task automatic tick(input bit v);
        model_accept(v, data_in1, data_in2);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [198:0] e;
        rst = 1'b0;
        data_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc = 0;
        model_expect(1'b0, e);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, e);
        end
        rst = 1'b1;
    endtask

    task automatic test_contiguous();
        logic [198:0] e;
        for (int i = 0; i < NP + LAT + 2; i++) begin
            bit v = (i < NP);
            drive(v);
            model_expect(v, e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL contiguous cyc%0d: got %h want %h", i, obs, e);
            end
            tick(v);
        end
    endtask

    task automatic test_gappy();
        logic [198:0] e;
        bit pat [11] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        int n_out = 0;
        int n_done = 0;
        for (int i = 0; i < 11 + LAT + 2; i++) begin
            bit v = (i < 11) ? pat[i] : 1'b0;
            drive(v);
            model_expect(v, e);
            n_out  += int'(data_out_valid);
            n_done += int'(frame_done);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL gappy cyc%0d: got %h want %h", i, obs, e);
            end
            tick(v);
        end
        checks++;
        if (n_out !== 8 || n_done !== 1) begin
            errors++;
            $display("FAIL gappy_counts: got outs=%0d dones=%0d want outs=8 dones=1", n_out, n_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [198:0] e;
        int done_at[$];
        int busy_low = 0;
        for (int i = 0; i < 2 * NP + LAT + 2; i++) begin
            bit v = (i < 2 * NP);
            drive(v);
            model_expect(v, e);
            if (frame_done === 1'b1) done_at.push_back(i);
            if (i < 2 * NP + LAT && busy !== 1'b1) busy_low++;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL b2b cyc%0d: got %h want %h", i, obs, e);
            end
            tick(v);
        end
        checks++;
        if (done_at.size() != 2 || busy_low != 0 ||
            (done_at.size() == 2 && done_at[1] - done_at[0] != NP)) begin
            errors++;
            $display("FAIL b2b_frames: got dones=%0d busy_low=%0d want dones=2 8 apart busy_low=0",
                     done_at.size(), busy_low);
        end
    endtask

    task automatic test_midframe_reset();
        logic [198:0] e;
        int n_done = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            model_expect(1'b1, e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL pre_reset cyc%0d: got %h want %h", i, obs, e);
            end
            tick(1'b1);
        end
        data_in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cyc++;
        model_expect(1'b0, e);
        checks++;
        if (obs !== {199{1'b0}} || obs !== e) begin
            errors++;
            $display("FAIL post_reset_zero: got %h want %h", obs, e);
        end
        tick(1'b0);
        for (int i = 0; i < NP + LAT + 2; i++) begin
            bit v = (i < NP);
            drive(v);
            if (i == 0) begin
                checks++;
                if (tf_addr !== 3'd0) begin
                    errors++;
                    $display("FAIL restart_addr: got %0d want 0", tf_addr);
                end
            end
            model_expect(v, e);
            n_done += int'(frame_done);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL post_reset cyc%0d: got %h want %h", i, obs, e);
            end
            tick(v);
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL reset_discard: got dones=%0d want 1", n_done);
        end
    endtask

    task automatic test_random();
        logic [198:0] e;
        for (int i = 0; i < 90; i++) begin
            bit v = (i < 84) ? ($urandom_range(0, 2) != 0) : 1'b0;
            drive(v);
            model_expect(v, e);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs, e);
            end
            tick(v);
        end
    endtask

    initial begin
        model_reset();
        cyc = 0;
        test_reset();
        test_contiguous();
        test_gappy();
        test_back_to_back();
        test_midframe_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
